// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and the
// bit-period helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH,  // wait for an idle (high) line before arming
    IDLE,       // armed, looking for a start-bit falling edge
    START,      // confirm the start bit at its midpoint
    DATA,       // sample eight data bits, LSB first
    STOP        // sample the stop bit and dispatch the byte
  } uart_state_e;

  // Rounded clocks per bit: (clk_freq + baud/2) / baud.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle of the UART receiver: read handshake, FIFO status
// and event pulses.
//   rd_en     pop request (ignored while empty)
//   rd_data   FIFO head, first-word fall-through, 0 while empty
//   empty/full/count  registered occupancy status
//   rx_ready/frame_err/overrun  one-cycle event pulses
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);
  logic                     rd_en;
  logic [UART_DATA_W-1:0]   rd_data;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     rx_ready;
  logic                     frame_err;
  logic                     overrun;

  // slave: the receiver; master: the downstream consumer
  modport slave  (input  rd_en,
                  output rd_data, empty, full, count, rx_ready, frame_err, overrun);
  modport master (output rd_en,
                  input  rd_data, empty, full, count, rx_ready, frame_err, overrun);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n  clock, async active-low reset
//   i_push      write i_wdata (accepted when not full, or full with a pop)
//   i_pop       remove head (ignored while empty)
//   o_rdata     head entry, 0 while empty
//   o_empty, o_full, o_count  registered occupancy
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_next;
  logic             r_empty, r_full;
  logic             w_push, w_pop;

  assign w_pop  = i_pop & ~r_empty;
  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign w_push = i_push & (~r_full | w_pop);

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all sequential state.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CW'(DEPTH));
    end
  end

  // NOTE: storage has no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a FWFT receive FIFO.
//   clk    system clock
//   reset  async active-low reset
//   rxd    asynchronous serial line, idles high
//   bus    consumer handshake and status (uart_rx_fifo_if.slave)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DEPTH     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rxd,
  uart_rx_fifo_if.slave bus
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);

  logic                   r_rxd_meta, r_rxd_sync;
  logic [1:0]             r_sync_vld;
  uart_state_e            r_state;
  logic [CNT_W-1:0]       r_clk_cnt;
  logic [2:0]             r_bit_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_rx_ready, r_frame_err, r_overrun;

  logic w_bit_end, w_stop_sample, w_push, w_drop, w_ferr, w_full;

  // Two-flop synchronizer, reset to the idle level. r_sync_vld marks when the
  // synchronizer holds real line samples, so the reset value of 1 cannot arm
  // the receiver while the line is actually held low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_sync_vld <= 2'b00;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  assign w_bit_end     = (r_clk_cnt == CNT_BIT_END);
  assign w_stop_sample = (r_state == STOP) && w_bit_end;
  assign w_push        = w_stop_sample &&  r_rxd_sync && (!w_full || bus.rd_en);
  assign w_drop        = w_stop_sample &&  r_rxd_sync &&   w_full && !bus.rd_en;
  assign w_ferr        = w_stop_sample && !r_rxd_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= WAIT_HIGH;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        WAIT_HIGH: if (r_sync_vld[1] && r_rxd_sync) r_state <= IDLE;
        IDLE: begin
          if (!r_rxd_sync) begin
            r_state   <= START;
            r_clk_cnt <= '0;
          end
        end
        START: begin
          if (r_clk_cnt == CNT_HALF_END) begin
            if (!r_rxd_sync) begin
              r_state   <= DATA;
              r_clk_cnt <= '0;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;  // glitch shorter than half a bit
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift[r_bit_idx] <= r_rxd_sync;
            r_clk_cnt          <= '0;
            if (r_bit_idx == 3'd7) r_state <= STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            // Leave at the sample point so a back-to-back start bit is caught.
            r_state   <= r_rxd_sync ? IDLE : WAIT_HIGH;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        default: r_state <= WAIT_HIGH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_ready  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_ready  <= w_push;
      r_frame_err <= w_ferr;
      r_overrun   <= w_drop;
    end
  end

  uart_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (bus.rd_en),
    .o_rdata (bus.rd_data),
    .o_empty (bus.empty),
    .o_full  (w_full),
    .o_count (bus.count)
  );

  assign bus.full      = w_full;
  assign bus.rx_ready  = r_rx_ready;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo with a queue-based model.
module tb_uart_rx_fifo;
  localparam int DEPTH   = 16;
  localparam int CPB     = 104;  // (1000000 + 4800) / 9600
  localparam int LAT_MIN = 990;
  localparam int LAT_MAX = 994;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rxd   = 1'b1;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (9600),
    .DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc++;

  // Pulse counters sampled mid-cycle.
  int n_rdy, n_ferr, n_ovr, t_rdy;
  always @(negedge clk) begin
    if (bus.rx_ready) begin
      n_rdy++;
      t_rdy = cyc;
    end
    if (bus.frame_err) n_ferr++;
    if (bus.overrun)   n_ovr++;
  end

  // Reference model
  logic [7:0] q[$];
  int exp_rdy, exp_ferr, exp_ovr;
  int n_pass, n_total;
  int t_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one 8N1 frame starting now (called at a falling clock edge).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    t_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1);
    if (q.size() < DEPTH) begin
      q.push_back(b);
      exp_rdy++;
    end else begin
      exp_ovr++;
    end
  endtask

  function automatic logic [7:0] head();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  task automatic pop_check(input string tag);
    check({tag, "_head"}, bus.rd_data, head());
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check({tag, "_count"}, bus.count, q.size());
    check({tag, "_empty"}, bus.empty, (q.size() == 0));
    check({tag, "_next"},  bus.rd_data, head());
  endtask

  initial begin
    logic [7:0] nb;
    int npop;
    bus.rd_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_empty",   bus.empty, 1'b1);
    check("rst_full",    bus.full, 1'b0);
    check("rst_count",   bus.count, 0);
    check("rst_pulses",  {bus.rx_ready, bus.frame_err, bus.overrun}, 3'b000);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with latency
    send_good(8'h55);
    check("t1_rdy", n_rdy, exp_rdy);
    check("t1_latency", (t_rdy - t_start >= LAT_MIN) && (t_rdy - t_start <= LAT_MAX), 1'b1);
    check("t1_data",  bus.rd_data, 8'h55);
    check("t1_count", bus.count, 1);
    pop_check("t1_pop");

    // Back-to-back pattern sweep
    send_good(8'hA5);
    send_good(8'h00);
    send_good(8'hFF);
    check("t2_rdy",  n_rdy, exp_rdy);
    check("t2_ferr", n_ferr, exp_ferr);
    for (int i = 0; i < 3; i++) pop_check("t2_pop");

    // Overflow: 17 bytes, no reads
    for (int i = 0; i <= 16; i++) begin
      send_good(8'(i));
      if (i == 15) begin
        check("t3_full",  bus.full, 1'b1);
        check("t3_count", bus.count, 16);
      end
    end
    check("t3_ovr",   n_ovr, exp_ovr);
    check("t3_rdy",   n_rdy, exp_rdy);
    check("t3_count_after", bus.count, 16);
    for (int i = 0; i < 16; i++) pop_check("t3_drain");

    // Full FIFO with a read in the push cycle
    for (int i = 0; i < 16; i++) send_good(8'($urandom));
    check("t4_full", bus.full, 1'b1);
    check("t4_head", bus.rd_data, head());
    nb = 8'($urandom);
    fork
      send_frame(nb, 1'b1);
      begin
        repeat (LAT_MIN) @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(nb);
    exp_rdy++;
    check("t4_ovr",   n_ovr, exp_ovr);
    check("t4_rdy",   n_rdy, exp_rdy);
    check("t4_count", bus.count, 16);
    check("t4_full2", bus.full, 1'b1);
    for (int i = 0; i < 16; i++) pop_check("t4_drain");

    // Framing error followed by a held-low line
    send_frame(8'h5A, 1'b0);
    rxd = 1'b0;
    exp_ferr++;
    repeat (1000) @(negedge clk);
    rxd = 1'b1;
    repeat (1200) @(negedge clk);
    check("t5_ferr",  n_ferr, exp_ferr);
    check("t5_rdy",   n_rdy, exp_rdy);
    check("t5_count", bus.count, 0);

    // Short glitch on an idle line
    rxd = 1'b0;
    repeat (30) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    check("t5g_rdy",  n_rdy, exp_rdy);
    check("t5g_ferr", n_ferr, exp_ferr);
    check("t5g_count", bus.count, 0);
    send_good(8'($urandom));
    check("t5g_rdy2", n_rdy, exp_rdy);
    pop_check("t5g_pop");

    // Reset during data bit 4 with three bytes queued
    for (int i = 0; i < 3; i++) send_good(8'($urandom));
    check("t6_count_pre", bus.count, 3);
    rxd = 1'b0;
    repeat (570) @(negedge clk);
    reset = 1'b0;
    #1;
    q.delete();
    check("t6_count", bus.count, 0);
    check("t6_empty", bus.empty, 1'b1);
    check("t6_data",  bus.rd_data, 8'h00);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (400) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    check("t6_rdy_none", n_rdy, exp_rdy);
    check("t6_count_post", bus.count, 0);
    send_good(8'h3C);
    check("t6_rdy", n_rdy, exp_rdy);
    pop_check("t6_pop");

    // Randomized traffic with random reads
    for (int i = 0; i < 10; i++) begin
      send_good(8'($urandom));
      check("t7_rdy", n_rdy, exp_rdy);
      check("t7_ovr", n_ovr, exp_ovr);
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) pop_check("t7_pop");
    end
    for (int i = 0; i < DEPTH && q.size() > 0; i++) pop_check("t7_drain");
    check("t7_empty", bus.empty, 1'b1);
    check("t7_ferr",  n_ferr, exp_ferr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
